// File: rtl/masked_sched_pkg.sv
// Shared types and helpers for the masked AND scheduler.
package masked_sched_pkg;

    localparam int SHARES = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRECH,
        S_EXEC,
        S_RESP
    } sched_state_t;

    typedef struct packed {
        logic a0;
        logic a1;
        logic b0;
        logic b1;
        logic c0;
        logic c1;
    } op_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/masked_and_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, wrapping.
module rr_arbiter
    import masked_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    idx
);

    int   j;
    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/three_input_and_gate_masked.sv
// Two-share masked three-input AND gadget; q[0] ^ q[1] = A & B & C.
module three_input_and_gate_masked (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic [1:0] c,
    input  logic       r,
    output logic [1:0] q
);

    // Each output share depends on only one share of A; r refreshes both.
    assign q[0] = (a[0] & b[0] & c[0]) ^ (a[0] & b[0] & c[1]) ^
                  (a[0] & b[1] & c[0]) ^ (a[0] & b[1] & c[1]) ^ r;
    assign q[1] = (a[1] & b[0] & c[0]) ^ (a[1] & b[0] & c[1]) ^
                  (a[1] & b[1] & c[0]) ^ (a[1] & b[1] & c[1]) ^ r;

endmodule

// File: rtl/masked_and_scheduler.sv
// Time-shares one masked 3-input AND gadget among NUM_REQ requesters.
// Optional PRECH state (all-zero gadget cycle) enabled by MASKED_SCHED_PRECHARGE_EN.
//   state | meaning
//   IDLE  | operand register zero, grant winner and latch its shares
//   PRECH | gadget inputs forced to zero, operands held aside
//   EXEC  | operand register drives gadget, result captured at edge
//   RESP  | result valid, wait for i_rsp_ready
module masked_and_scheduler
    import masked_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [NUM_REQ-1:0] i_A0,
    input  logic [NUM_REQ-1:0] i_A1,
    input  logic [NUM_REQ-1:0] i_B0,
    input  logic [NUM_REQ-1:0] i_B1,
    input  logic [NUM_REQ-1:0] i_C0,
    input  logic [NUM_REQ-1:0] i_C1,
    input  logic               i_rN,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic [ID_W-1:0]    o_rsp_id,
    output logic               o_out0,
    output logic               o_out1,
    output logic               o_busy
);

    sched_state_t      state;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   ptr_nxt;
    logic [ID_W-1:0]   arb_idx;
    logic [ID_W-1:0]   rsp_id;
    logic [NUM_REQ-1:0] arb_gnt;
    op_t               op_reg;
    op_t               op_sel;
    op_t               g_in;
    logic              g_r;
    logic [SHARES-1:0] g_out;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req (i_req),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    assign op_sel  = '{a0: i_A0[arb_idx], a1: i_A1[arb_idx],
                       b0: i_B0[arb_idx], b1: i_B1[arb_idx],
                       c0: i_C0[arb_idx], c1: i_C1[arb_idx]};
    assign ptr_nxt = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;

    // Gadget sees operands and randomness only during EXEC; zero otherwise.
    assign g_in = (state == S_EXEC) ? op_reg : '0;
    assign g_r  = (state == S_EXEC) & i_rN;

    three_input_and_gate_masked u_gadget (
        .a ({g_in.a1, g_in.a0}),
        .b ({g_in.b1, g_in.b0}),
        .c ({g_in.c1, g_in.c0}),
        .r (g_r),
        .q (g_out)
    );

    assign o_gnt    = (state == S_IDLE) ? arb_gnt : '0;
    assign o_busy   = (state != S_IDLE);
    assign o_rsp_id = rsp_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ptr         <= '0;
            op_reg      <= '0;
            rsp_id      <= '0;
            o_rsp_valid <= 1'b0;
            o_out0      <= 1'b0;
            o_out1      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|i_req) begin
                        op_reg <= op_sel;
                        rsp_id <= arb_idx;
                        ptr    <= ptr_nxt;
`ifdef MASKED_SCHED_PRECHARGE_EN
                        state  <= S_PRECH;
`else
                        state  <= S_EXEC;
`endif
                    end
                end
                S_PRECH: state <= S_EXEC;
                S_EXEC: begin
                    o_out0      <= g_out[0];
                    o_out1      <= g_out[1];
                    o_rsp_valid <= 1'b1;
                    state       <= S_RESP;
                end
                S_RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        op_reg      <= '0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_masked_and_scheduler.sv
// Scoreboard bench for masked_and_scheduler (NUM_REQ=4).
module tb_masked_and_scheduler;

`ifdef MASKED_SCHED_PRECHARGE_EN
    localparam int LAT    = 3;
    localparam int PERIOD = 4;
`else
    localparam int LAT    = 2;
    localparam int PERIOD = 3;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] i_req, i_A0, i_A1, i_B0, i_B1, i_C0, i_C1;
    logic       i_rN, i_rsp_ready;
    logic [3:0] o_gnt;
    logic       o_rsp_valid, o_out0, o_out1, o_busy;
    logic [1:0] o_rsp_id;

    typedef struct {
        int   id;
        logic res;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    masked_and_scheduler #(.NUM_REQ(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req       (i_req),
        .i_A0        (i_A0),
        .i_A1        (i_A1),
        .i_B0        (i_B0),
        .i_B1        (i_B1),
        .i_C0        (i_C0),
        .i_C1        (i_C1),
        .i_rN        (i_rN),
        .o_gnt       (o_gnt),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_id    (o_rsp_id),
        .o_out0      (o_out0),
        .o_out1      (o_out1),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Monitor: every accepted response is matched against the queue head.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && o_rsp_valid && i_rsp_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rsp_unexpected: got id %0d with no response expected", o_rsp_id);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_id", 32'(o_rsp_id), 32'(e.id));
                chk("rsp_data", 32'(o_out0 ^ o_out1), 32'(e.res));
            end
        end
    end

    function automatic logic and_model(input logic [5:0] sh);
        return (sh[5] ^ sh[4]) & (sh[3] ^ sh[2]) & (sh[1] ^ sh[0]);
    endfunction

    task automatic set_shares(input int k, input logic [5:0] sh);
        {i_A0[k], i_A1[k], i_B0[k], i_B1[k], i_C0[k], i_C1[k]} = sh;
    endtask

    task automatic wait_gnt(input int k);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (o_gnt[k]) break;
        end
        chk($sformatf("gnt_%0d", k), 32'(o_gnt), 32'(4'b1 << k));
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!o_busy) break;
        end
        chk("return_idle", 32'(o_busy), 32'd0);
    endtask

    task automatic wait_valid();
        for (int c = 0; c < 40; c++) begin
            if (o_rsp_valid) break;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input int k, input logic [5:0] sh, input logic rn, input logic er);
        int t0;
        exp_t e;
        @(posedge clk); #1;
        set_shares(k, sh);
        i_rN     = rn;
        i_req[k] = 1'b1;
        wait_gnt(k);
        t0    = cyc;
        e.id  = k;
        e.res = er;
        sb.push_back(e);
        @(posedge clk); #1;
        i_req[k] = 1'b0;
        @(negedge clk);
`ifdef MASKED_SCHED_PRECHARGE_EN
        chk("prech_zero", 32'(dut.g_in), 32'd0);
        chk("prech_no_valid", 32'(o_rsp_valid), 32'd0);
        @(negedge clk);
`endif
        chk("exec_no_valid", 32'(o_rsp_valid), 32'd0);
        wait_valid();
        chk("latency", 32'(cyc - t0), 32'(LAT));
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   tp;
        logic s0, s1;
        exp_t e;

        rst_n = 1'b0;
        i_req = '0;
        {i_A0, i_A1, i_B0, i_B1, i_C0, i_C1} = '0;
        i_rN = 1'b0;
        i_rsp_ready = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(o_gnt), 32'd0);
        chk("rst_valid", 32'(o_rsp_valid), 32'd0);
        chk("rst_id", 32'(o_rsp_id), 32'd0);
        chk("rst_out", 32'({o_out0, o_out1}), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Fairness: all four requesting, ptr starts at 0
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) set_shares(k, 6'b101010);
        i_req = 4'hF;
        tp = 0;
        for (int n = 0; n < 5; n++) begin
            wait_gnt(n % 4);
            if (n > 0) chk("rr_period", 32'(cyc - tp), 32'(PERIOD));
            tp    = cyc;
            e.id  = n % 4;
            e.res = 1'b1;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        i_req = '0;
        wait_idle();

        // Single request: requester 2, A=(1,0) B=(0,1) C=(1,0), rN=1
        run_op(2, 6'b100110, 1'b1, 1'b1);
        run_op(1, 6'b110110, 1'b0, 1'b0);
        run_op(3, 6'b011001, 1'b1, 1'b1);

        // Back-pressure: requester 1 stalled in RESP, requester 3 waiting
        @(posedge clk); #1;
        set_shares(1, 6'b011001);
        set_shares(3, 6'b000000);
        i_rsp_ready = 1'b0;
        i_req[1] = 1'b1;
        wait_gnt(1);
        e.id = 1; e.res = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        i_req[1] = 1'b0;
        i_req[3] = 1'b1;
        @(negedge clk);
        wait_valid();
        s0 = o_out0;
        s1 = o_out1;
        for (int n = 0; n < 5; n++) begin
            if (n > 0) @(negedge clk);
            chk("bp_valid", 32'(o_rsp_valid), 32'd1);
            chk("bp_id", 32'(o_rsp_id), 32'd1);
            chk("bp_xor", 32'(o_out0 ^ o_out1), 32'd1);
            chk("bp_stable", 32'({o_out0, o_out1}), 32'({s0, s1}));
            chk("bp_no_gnt", 32'(o_gnt), 32'd0);
        end
        @(posedge clk); #1;
        i_rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_next_gnt", 32'(o_gnt), 32'b1000);
        e.id = 3; e.res = 1'b0;
        sb.push_back(e);
        @(posedge clk); #1;
        i_req[3] = 1'b0;
        wait_idle();

        // Reset mid-operation: op for requester 2 aborted, ptr back to 0
        @(posedge clk); #1;
        set_shares(2, 6'b101010);
        i_req[2] = 1'b1;
        wait_gnt(2);
        @(posedge clk); #1;
        i_req = '0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 32'(o_rsp_valid), 32'd0);
        chk("mid_rst_out", 32'({o_out0, o_out1}), 32'd0);
        chk("mid_rst_busy", 32'(o_busy), 32'd0);
        chk("mid_rst_gnt", 32'(o_gnt), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_shares(0, 6'b100110);
        set_shares(3, 6'b111111);
        i_req = 4'b1001;
        @(negedge clk);
        chk("post_rst_no_valid", 32'(o_rsp_valid), 32'd0);
        chk("post_rst_first", 32'(o_gnt), 32'b0001);
        e.id = 0; e.res = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        i_req[0] = 1'b0;
        wait_gnt(3);
        e.id = 3; e.res = 1'b0;
        sb.push_back(e);
        @(posedge clk); #1;
        i_req[3] = 1'b0;
        wait_idle();

        // Exhaustive share combinations x rN
        for (int v = 0; v < 64; v++) begin
            for (int rn = 0; rn < 2; rn++) begin
                logic [5:0] sh;
                sh = 6'(v);
                run_op((2 * v + rn) % 4, sh, 1'(rn), and_model(sh));
            end
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
